// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Arbitrates one single-ported unified instruction/data memory between the
// MEM stage and a sequential instruction prefetcher. Data accesses always win
// the port. Idle port cycles fill a small {pc, instr} queue that the IF stage
// drains with a valid/ready handshake. A redirect flushes the queue and
// restarts fetch at the new PC.
// Optional feature: define ARB_PERF_CNT_EN to add the performance counters
// perf_fetch_slots_lost and perf_if_starve.
module unified_mem_arbiter #(
    parameter int                ADDR_W   = 8,
    parameter int                QDEPTH   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,

    // Fetch-side control and IF handshake
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              if_ready,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,

    // MEM-stage data access
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [2:0]        d_func3,
    output logic [31:0]       d_rdata,

    // Memory port
    output logic              m_MemRead,
    output logic              m_MemWrite,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_data_in,
    output logic [2:0]        m_func3,
    input  logic [31:0]       m_data_out
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_slots_lost,
    output logic [31:0]       perf_if_starve
`endif
);

    // Queue depth is a power of two, so pointers wrap naturally.
    localparam int               PTR_W    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int               CNT_W    = $clog2(QDEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] q_pc    [QDEPTH];
    logic [31:0]       q_instr [QDEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic not_full;
    logic pop;
    logic push;

    // Head of queue is presented directly; when empty it is stale and ignored.
    assign if_valid = (count != '0);
    assign if_pc    = q_pc[rd_ptr];
    assign if_instr = q_instr[rd_ptr];

    // A redirect cycle neither pops nor pushes: the queue is being discarded.
    // A push into a full queue is allowed when the head leaves in the same cycle.
    assign not_full = (count < FULL_CNT);
    assign pop      = if_valid & if_ready & ~redirect;
    assign push     = ~d_req & ~redirect & (not_full | pop);

    // Load data comes straight from the memory in the request cycle.
    assign d_rdata = m_data_out;

    // Port mux: a data access owns the port, otherwise the fetch address is
    // presented as an instruction-region read. Strobes are gated by reset so
    // the memory can never be written while the core is held in reset.
    always_comb begin
        m_MemRead  = 1'b0;
        m_MemWrite = 1'b0;
        m_addr     = fetch_pc;
        m_data_in  = '0;
        m_func3    = '0;
        if (d_req) begin
            m_MemRead  = ~d_we & rst_n;
            m_MemWrite = d_we & rst_n;
            m_addr     = d_addr;
            m_data_in  = d_wdata;
            m_func3    = d_func3;
        end
    end

    // Fetch PC, queue pointers and occupancy; redirect overrides push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + ADDR_W'(4);
                wr_ptr   <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage: capture the fetched word together with its address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else if (push) begin
            q_pc[wr_ptr]    <= fetch_pc;
            q_instr[wr_ptr] <= m_data_out;
        end
    end

`ifdef ARB_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    // Saturating counters: data accesses that steal a usable fetch slot, and
    // cycles where the IF stage has nothing to take.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_slots_lost <= '0;
            perf_if_starve        <= '0;
        end else begin
            if (d_req && not_full) begin
                perf_fetch_slots_lost <= sat_inc(perf_fetch_slots_lost);
            end
            if (!if_valid) begin
                perf_if_starve <= sat_inc(perf_if_starve);
            end
        end
    end
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Testbench for unified_mem_arbiter: directed scenarios followed by random
// traffic, checked against a queue-based behavioural model and a word memory.
module tb_unified_mem_arbiter;
    localparam int         ADDR_W   = 8;
    localparam int         QDEPTH   = 2;
    localparam logic [7:0] RESET_PC = 8'h00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        if_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [7:0]  if_pc;
    logic        d_req;
    logic        d_we;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_func3;
    logic [31:0] d_rdata;
    logic        m_MemRead;
    logic        m_MemWrite;
    logic [7:0]  m_addr;
    logic [31:0] m_data_in;
    logic [2:0]  m_func3;
    logic [31:0] m_data_out;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_fetch_slots_lost;
    logic [31:0] perf_if_starve;
`endif

    // Memory attached to the DUT port (combinational read, write at edge)
    logic [31:0] mem [64];
    assign m_data_out = mem[m_addr[7:2]];

    // Reference model state
    logic [7:0]  pc_q  [$];
    logic [31:0] ins_q [$];
    logic [7:0]  mfetch;
    logic [31:0] rmem [64];

    int vectors = 0;
    int miscompares = 0;

    unified_mem_arbiter #(.ADDR_W(ADDR_W), .QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect(redirect), .redirect_pc(redirect_pc), .if_ready(if_ready),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_func3(d_func3), .d_rdata(d_rdata),
        .m_MemRead(m_MemRead), .m_MemWrite(m_MemWrite), .m_addr(m_addr),
        .m_data_in(m_data_in), .m_func3(m_func3), .m_data_out(m_data_out)
`ifdef ARB_PERF_CNT_EN
        , .perf_fetch_slots_lost(perf_fetch_slots_lost), .perf_if_starve(perf_if_starve)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1, "watchdog expired");
    end

    // Apply inputs (called just after a rising edge) and let them settle
    task automatic drive(input logic req, input logic we, input logic [7:0] addr,
                         input logic [31:0] wd, input logic [2:0] f3,
                         input logic rdy, input logic rd, input logic [7:0] rpc);
        d_req = req; d_we = we; d_addr = addr; d_wdata = wd; d_func3 = f3;
        if_ready = rdy; redirect = rd; redirect_pc = rpc;
        #1;
    endtask

    task automatic model_reset();
        pc_q.delete();
        ins_q.delete();
        mfetch = RESET_PC;
    endtask

    // Advance one clock: update the model from the queue rules, then commit
    // any store the DUT presented to the attached memory.
    task automatic tick();
        bit          pop;
        bit          push;
        logic        mw;
        logic [7:0]  ma;
        logic [31:0] md;
        pop  = (pc_q.size() != 0) && if_ready && !redirect;
        push = !d_req && !redirect && ((pc_q.size() < QDEPTH) || pop);
        mw = m_MemWrite; ma = m_addr; md = m_data_in;
        if (redirect) begin
            pc_q.delete();
            ins_q.delete();
            mfetch = redirect_pc;
        end else begin
            if (pop) begin
                void'(pc_q.pop_front());
                void'(ins_q.pop_front());
            end
            if (push) begin
                pc_q.push_back(mfetch);
                ins_q.push_back(rmem[mfetch[7:2]]);
                mfetch = mfetch + 8'd4;
            end
        end
        if (d_req && d_we) rmem[d_addr[7:2]] = d_wdata;
        @(posedge clk);
        #1;
        if (mw) mem[ma[7:2]] = md;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        drive(1'b1, 1'b1, 8'h10, 32'h1234_5678, 3'd2, 1'b0, 1'b0, 8'h00);
        vectors++; if (m_MemWrite !== 1'b0) begin miscompares++; $display("FAIL rst_memwrite got %b want 0", m_MemWrite); end
        vectors++; if (m_MemRead !== 1'b0) begin miscompares++; $display("FAIL rst_memread got %b want 0", m_MemRead); end
        vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL rst_if_valid got %b want 0", if_valid); end
        vectors++; if (if_pc !== 8'h00) begin miscompares++; $display("FAIL rst_if_pc got %h want 00", if_pc); end
        vectors++; if (if_instr !== 32'h0) begin miscompares++; $display("FAIL rst_if_instr got %h want 0", if_instr); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        drive(1'b0, 1'b0, 8'h00, 32'h0, 3'd0, 1'b0, 1'b0, 8'h00);
        vectors++; if (m_addr !== RESET_PC) begin miscompares++; $display("FAIL rst_fetch_addr got %h want %h", m_addr, RESET_PC); end
        tick();
        vectors++; if (if_valid !== 1'b1) begin miscompares++; $display("FAIL fill1_valid got %b want 1", if_valid); end
        vectors++; if (if_pc !== 8'h00) begin miscompares++; $display("FAIL fill1_pc got %h want 00", if_pc); end
        vectors++; if (if_instr !== 32'h0000_0013) begin miscompares++; $display("FAIL fill1_instr got %h want 00000013", if_instr); end
        tick();
        vectors++; if (m_addr !== 8'h08) begin miscompares++; $display("FAIL fill2_fetch_addr got %h want 08", m_addr); end
        tick();
        vectors++; if (m_addr !== 8'h08) begin miscompares++; $display("FAIL full_no_push got %h want 08", m_addr); end
        vectors++; if (if_pc !== 8'h00) begin miscompares++; $display("FAIL full_head_pc got %h want 00", if_pc); end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 8'h00, 32'h0, 3'd0, 1'b1, 1'b0, 8'h00);
            vectors++; if (if_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d] got %b want 1", k, if_valid); end
            vectors++; if (if_pc !== 8'(k * 4)) begin miscompares++; $display("FAIL stream_pc[%0d] got %h want %h", k, if_pc, 8'(k * 4)); end
            vectors++; if (if_instr !== rmem[k]) begin miscompares++; $display("FAIL stream_instr[%0d] got %h want %h", k, if_instr, rmem[k]); end
            tick();
        end
        drive(1'b0, 1'b0, 8'h00, 32'h0, 3'd0, 1'b0, 1'b0, 8'h00);
        vectors++; if (if_pc !== 8'h10) begin miscompares++; $display("FAIL stream_end_pc got %h want 10", if_pc); end
        vectors++; if (m_addr !== 8'h18) begin miscompares++; $display("FAIL stream_end_fetch got %h want 18", m_addr); end
    endtask

    task automatic test_store_load();
        drive(1'b1, 1'b1, 8'h0C, 32'hDEAD_BEEF, 3'b010, 1'b1, 1'b0, 8'h00);
        vectors++; if (m_MemWrite !== 1'b1) begin miscompares++; $display("FAIL store_memwrite got %b want 1", m_MemWrite); end
        vectors++; if (m_MemRead !== 1'b0) begin miscompares++; $display("FAIL store_memread got %b want 0", m_MemRead); end
        vectors++; if (m_addr !== 8'h0C) begin miscompares++; $display("FAIL store_addr got %h want 0c", m_addr); end
        vectors++; if (m_data_in !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL store_data got %h want deadbeef", m_data_in); end
        vectors++; if (m_func3 !== 3'b010) begin miscompares++; $display("FAIL store_func3 got %b want 010", m_func3); end
        tick();
        drive(1'b1, 1'b0, 8'h0C, 32'h0, 3'b010, 1'b0, 1'b0, 8'h00);
        vectors++; if (d_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL load_rdata got %h want deadbeef", d_rdata); end
        vectors++; if (m_MemRead !== 1'b1) begin miscompares++; $display("FAIL load_memread got %b want 1", m_MemRead); end
        vectors++; if (m_MemWrite !== 1'b0) begin miscompares++; $display("FAIL load_memwrite got %b want 0", m_MemWrite); end
        tick();
        drive(1'b0, 1'b0, 8'h00, 32'h0, 3'd0, 1'b0, 1'b0, 8'h00);
        vectors++; if (m_addr !== 8'h18) begin miscompares++; $display("FAIL dreq_no_push got %h want 18", m_addr); end
        vectors++; if (if_pc !== 8'h14) begin miscompares++; $display("FAIL store_pop_pc got %h want 14", if_pc); end
        tick();
    endtask

    task automatic test_redirect();
        drive(1'b1, 1'b0, 8'h0C, 32'h0, 3'd2, 1'b1, 1'b1, 8'h40);
        vectors++; if (if_valid !== 1'b1) begin miscompares++; $display("FAIL redir_cycle_valid got %b want 1", if_valid); end
        vectors++; if (d_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL redir_dreq_rdata got %h want deadbeef", d_rdata); end
        vectors++; if (m_MemRead !== 1'b1) begin miscompares++; $display("FAIL redir_dreq_memread got %b want 1", m_MemRead); end
        tick();
        drive(1'b0, 1'b0, 8'h00, 32'h0, 3'd0, 1'b0, 1'b0, 8'h00);
        vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL redir_flush_valid got %b want 0", if_valid); end
        vectors++; if (m_addr !== 8'h40) begin miscompares++; $display("FAIL redir_fetch_addr got %h want 40", m_addr); end
        tick();
        vectors++; if (if_valid !== 1'b1) begin miscompares++; $display("FAIL redir_refill_valid got %b want 1", if_valid); end
        vectors++; if (if_pc !== 8'h40) begin miscompares++; $display("FAIL redir_refill_pc got %h want 40", if_pc); end
        vectors++; if (if_instr !== rmem[16]) begin miscompares++; $display("FAIL redir_refill_instr got %h want %h", if_instr, rmem[16]); end
        tick();
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b0, 8'h00, 32'h0, 3'd0, 1'b0, 1'b1, 8'hF8);
        tick();
        drive(1'b0, 1'b0, 8'h00, 32'h0, 3'd0, 1'b0, 1'b0, 8'h00);
        vectors++; if (m_addr !== 8'hF8) begin miscompares++; $display("FAIL wrap_addr_f8 got %h want f8", m_addr); end
        tick();
        vectors++; if (m_addr !== 8'hFC) begin miscompares++; $display("FAIL wrap_addr_fc got %h want fc", m_addr); end
        tick();
        drive(1'b0, 1'b0, 8'h00, 32'h0, 3'd0, 1'b1, 1'b0, 8'h00);
        vectors++; if (m_addr !== 8'h00) begin miscompares++; $display("FAIL wrap_addr_00 got %h want 00", m_addr); end
        vectors++; if (if_pc !== 8'hF8) begin miscompares++; $display("FAIL wrap_head_f8 got %h want f8", if_pc); end
        tick();
        vectors++; if (if_pc !== 8'hFC) begin miscompares++; $display("FAIL wrap_head_fc got %h want fc", if_pc); end
        tick();
        drive(1'b0, 1'b0, 8'h00, 32'h0, 3'd0, 1'b0, 1'b0, 8'h00);
        vectors++; if (if_pc !== 8'h00) begin miscompares++; $display("FAIL wrap_head_00 got %h want 00", if_pc); end
        vectors++; if (if_instr !== rmem[0]) begin miscompares++; $display("FAIL wrap_instr_00 got %h want %h", if_instr, rmem[0]); end
        tick();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 8'h20, 32'hCAFE_F00D, 3'd2, 1'b1, 1'b0, 8'h00);
        vectors++; if (if_valid !== 1'b1) begin miscompares++; $display("FAIL arst_pre_valid got %b want 1", if_valid); end
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid got %b want 0", if_valid); end
        vectors++; if (m_MemWrite !== 1'b0) begin miscompares++; $display("FAIL arst_memwrite got %b want 0", m_MemWrite); end
        vectors++; if (if_pc !== 8'h00) begin miscompares++; $display("FAIL arst_if_pc got %h want 00", if_pc); end
        model_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 32'h0, 3'd0, 1'b0, 1'b0, 8'h00);
        vectors++; if (m_addr !== RESET_PC) begin miscompares++; $display("FAIL arst_restart_addr got %h want %h", m_addr, RESET_PC); end
        vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL arst_release_valid got %b want 0", if_valid); end
        tick();
        vectors++; if (if_valid !== 1'b1) begin miscompares++; $display("FAIL arst_first_valid got %b want 1", if_valid); end
        vectors++; if (if_pc !== RESET_PC) begin miscompares++; $display("FAIL arst_first_pc got %h want %h", if_pc, RESET_PC); end
    endtask

    task automatic test_random();
        logic [48:0] exp_port;
        logic [48:0] act_port;
        for (int c = 0; c < 500; c++) begin
            drive(($urandom_range(0, 2) == 0), 1'($urandom), 8'($urandom), $urandom,
                  3'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                  8'($urandom));
            vectors++;
            if (if_valid !== (pc_q.size() != 0)) begin
                miscompares++;
                $display("FAIL rnd_valid cyc %0d got %b want %b", c, if_valid, (pc_q.size() != 0));
            end
            if (pc_q.size() != 0) begin
                vectors++;
                if ({if_pc, if_instr} !== {pc_q[0], ins_q[0]}) begin
                    miscompares++;
                    $display("FAIL rnd_head cyc %0d got %h/%h want %h/%h", c, if_pc, if_instr, pc_q[0], ins_q[0]);
                end
            end
            if (d_req) exp_port = {!d_we, d_we, d_addr, d_wdata, d_func3};
            else       exp_port = {1'b0, 1'b0, mfetch, 32'h0, 3'h0};
            act_port = {m_MemRead, m_MemWrite, m_addr, m_data_in, m_func3};
            vectors++;
            if (act_port !== exp_port) begin
                miscompares++;
                $display("FAIL rnd_port cyc %0d got %h want %h", c, act_port, exp_port);
            end
            if (d_req && !d_we) begin
                vectors++;
                if (d_rdata !== rmem[d_addr[7:2]]) begin
                    miscompares++;
                    $display("FAIL rnd_load cyc %0d got %h want %h", c, d_rdata, rmem[d_addr[7:2]]);
                end
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        for (int i = 0; i < 64; i++) rmem[i] = mem[i];
        model_reset();
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_func3 = '0;
        if_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        test_reset();
        test_stream();
        test_store_load();
        test_redirect();
        test_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
